// File: rtl/team_06_i2s_pkg.sv
// Shared definitions for the I2S ADC receiver: FSM states, default geometry
// and the bit-counter width helper.
package team_06_i2s_pkg;

  localparam int CLK_DIV_DEF   = 4;
  localparam int SLOT_BITS_DEF = 32;
  localparam int DATA_W_DEF    = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/team_06_i2s_clkgen.sv
// Bit-clock divider: i2sclk toggles every CLK_DIV hwclk cycles while en=1,
// with a capture strobe on the last high cycle and a strobe on the falling cycle.
module team_06_i2s_clkgen
  import team_06_i2s_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic hwclk,
  input  logic reset,
  input  logic en,
  output logic i2sclk,
  output logic fall_stb,
  output logic cap_stb
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          clk_q, clk_d;
  logic          fall_q, fall_d;
  logic          last_cyc;

  assign last_cyc = (div_q == DIV_LAST);
  assign cap_stb  = en && clk_q && last_cyc;

  always_comb begin
    div_d  = div_q;
    clk_d  = clk_q;
    fall_d = cap_stb;
    if (!en) begin
      div_d = '0;
      clk_d = 1'b0;
    end else if (last_cyc) begin
      div_d = '0;
      clk_d = ~clk_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      clk_q  <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      clk_q  <= clk_d;
      fall_q <= fall_d;
    end
  end

  assign i2sclk   = clk_q;
  assign fall_stb = fall_q;

endmodule

// File: rtl/team_06_i2s_adc_rx.sv
// I2S ADC receiver: drives bit clock / word select, deserialises samples and
// hands them out over valid/ready. Define I2S_RX_STEREO_EN to emit right slots too.
module team_06_i2s_adc_rx
  import team_06_i2s_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic              en,
  input  logic              adc_serial_in,
  output logic              i2sclk,
  output logic              ws_adc,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);

  localparam int BW = cnt_w(SLOT_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] LSB_BIT  = BW'(DATA_W);

  logic fall_stb, cap_stb;

  team_06_i2s_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .hwclk    (hwclk),
    .reset    (reset),
    .en       (en),
    .i2sclk   (i2sclk),
    .fall_stb (fall_stb),
    .cap_stb  (cap_stb)
  );

  logic [1:0] sync_q;
  logic       sdi;

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], adc_serial_in};
  end

  assign sdi = sync_q[1];

  state_e            state_q, state_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              ws_q, ws_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, shreg_nx;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              slot_en, in_data, shift_en, complete;

`ifdef I2S_RX_STEREO_EN
  logic right_q, right_d;
  assign slot_en      = 1'b1;
  assign sample_right = right_q;
`else
  assign slot_en      = ~ws_q;
  assign sample_right = 1'b0;
`endif

  // Slot MSB sits at b=1; b=0 carries the previous slot's tail.
  assign in_data  = (bit_q != '0) && (bit_q <= LSB_BIT);
  assign shift_en = (state_q == ST_RUN) && cap_stb && slot_en && in_data;
  assign complete = shift_en && (bit_q == LSB_BIT);
  assign shreg_nx = {shreg_q[DATA_W-2:0], sdi};

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    ws_d    = ws_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: state_d = ST_SYNC;
      ST_SYNC: if (fall_stb && (bit_q == LAST_BIT) && ws_q) state_d = ST_RUN;
      default: ;
    endcase
    if (fall_stb) begin
      if (bit_q == LAST_BIT) begin
        bit_d = '0;
        ws_d  = ~ws_q;
      end else begin
        bit_d = bit_q + 1'b1;
      end
    end
    if (shift_en) shreg_d = shreg_nx;
    if (!en) begin
      state_d = ST_IDLE;
      bit_d   = '0;
      ws_d    = 1'b0;
      shreg_d = '0;
    end
  end

  // A completing sample only replaces the held one if that one leaves this cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = 1'b0;
`ifdef I2S_RX_STEREO_EN
    right_d = right_q;
`endif
    if (complete) begin
      if (!valid_q || sample_ready) begin
        data_d  = shreg_nx;
        valid_d = 1'b1;
`ifdef I2S_RX_STEREO_EN
        right_d = ws_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      ws_q    <= 1'b0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      ws_q    <= ws_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef I2S_RX_STEREO_EN
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) right_q <= 1'b0;
    else       right_q <= right_d;
  end
`endif

  assign ws_adc       = ws_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_team_06_i2s_adc_rx.sv
// Scoreboard bench for team_06_i2s_adc_rx with an I2S ADC model; expectations
// follow I2S_RX_STEREO_EN when it is defined for the build.
module tb_team_06_i2s_adc_rx;

`ifdef I2S_RX_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif
  localparam int DROP_AT = STEREO ? 967 : 1223;
  localparam int REL_AT  = DROP_AT + 33;
  localparam logic [23:0] SECOND = STEREO ? 24'h7FFFFE : 24'h123456;

  logic        hwclk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        adc_serial_in = 1'b0;
  logic        sample_ready = 1'b0;
  logic        i2sclk, ws_adc, sample_right, sample_valid, overrun;
  logic [23:0] sample_data;

  always #5 hwclk = ~hwclk;

  team_06_i2s_adc_rx dut (
    .hwclk         (hwclk),
    .reset         (reset),
    .en            (en),
    .adc_serial_in (adc_serial_in),
    .i2sclk        (i2sclk),
    .ws_adc        (ws_adc),
    .sample_data   (sample_data),
    .sample_right  (sample_right),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun)
  );

  logic [24:0] exp_q[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, base = 0;
  int ov_cnt = 0, vcyc = 0;
  int ov0, vc0;

  // Slot words in order since enable: two SYNC slots, then L/R pairs.
  logic [23:0] words [8] = '{24'h111111, 24'h222222, 24'h800001, 24'h7FFFFE,
                             24'h123456, 24'hABCDEF, 24'hFFFFFF, 24'h5A5A5A};
  int   m_idx = 0, m_sc = 0;
  logic m_prev_ws = 1'b0;
  logic [23:0] m_word;

  always @(posedge hwclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic at(input int n);
    while (cyc - base < n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  task automatic push(input logic [23:0] d, input logic r);
    exp_q.push_back({d, r});
  endtask

  task automatic start_phase(input logic rdy);
    @(posedge hwclk);
    #1;
    sample_ready = rdy;
    m_idx = 0;
    m_sc = 0;
    m_prev_ws = 1'b0;
    en = 1'b1;
    base = cyc + 1;
  endtask

  task automatic stop_phase();
    en = 1'b0;
    repeat (20) @(posedge hwclk);
    #1;
  endtask

  // ADC model: launches the next bit shortly after each falling bit-clock edge.
  initial begin
    forever begin
      @(negedge i2sclk);
      repeat (2) @(posedge hwclk);
      #1;
      if (!en) begin
        m_idx = 0;
        m_sc = 0;
        m_prev_ws = 1'b0;
        adc_serial_in = 1'b0;
      end else begin
        if (ws_adc != m_prev_ws) begin
          m_idx = 0;
          m_sc++;
        end else begin
          m_idx++;
        end
        m_prev_ws = ws_adc;
        m_word = words[m_sc % 8];
        if (m_idx >= 1 && m_idx <= 24) adc_serial_in = m_word[24 - m_idx];
        else adc_serial_in = 1'b0;
      end
    end
  end

  // Monitor: every accepted sample is popped from the scoreboard and compared.
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge hwclk);
      if (overrun === 1'b1) ov_cnt++;
      if (sample_valid === 1'b1) vcyc++;
      if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_sample: got data 0x%06h right %0b, required none",
                   sample_data, sample_right);
        end else begin
          e = exp_q.pop_front();
          $display("sample data=0x%06h right=%0b (expected 0x%06h right=%0b)",
                   sample_data, sample_right, e[24:1], e[0]);
          chk("sample_data", {8'h0, sample_data}, {8'h0, e[24:1]});
          chk("sample_right", {31'h0, sample_right}, {31'h0, e[0]});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge hwclk);
    #1;
    chk("rst_i2sclk", {31'h0, i2sclk}, 0);
    chk("rst_ws", {31'h0, ws_adc}, 0);
    chk("rst_valid", {31'h0, sample_valid}, 0);
    chk("rst_data", {8'h0, sample_data}, 0);
    chk("rst_right", {31'h0, sample_right}, 0);
    chk("rst_overrun", {31'h0, overrun}, 0);
    reset = 1'b0;
    repeat (2) @(posedge hwclk);
    #1;

    // Enable, clocking and data capture with ready tied high
    push(24'h800001, 1'b0);
    if (STEREO) push(24'h7FFFFE, 1'b1);
    push(24'h123456, 1'b0);
    if (STEREO) push(24'hABCDEF, 1'b1);
    push(24'hFFFFFF, 1'b0);
    vc0 = vcyc;
    start_phase(1'b1);
    at(2);   chk("i2sclk_c2", {31'h0, i2sclk}, 0);
    at(3);   chk("i2sclk_c3", {31'h0, i2sclk}, 1);
    at(7);   chk("i2sclk_c7", {31'h0, i2sclk}, 0);
    at(11);  chk("i2sclk_c11", {31'h0, i2sclk}, 1);
    at(255); chk("ws_c255", {31'h0, ws_adc}, 0);
    at(256); chk("ws_c256", {31'h0, ws_adc}, 1);
    at(511); chk("ws_c511", {31'h0, ws_adc}, 1);
    at(512); chk("ws_c512", {31'h0, ws_adc}, 0);
    at(710);
    chk("no_valid_sync_frame", vcyc - vc0, 0);
    chk("valid_c710", {31'h0, sample_valid}, 0);
    at(711);
    chk("valid_c711", {31'h0, sample_valid}, 1);
    chk("data_c711", {8'h0, sample_data}, 32'h800001);
    at(712); chk("valid_c712", {31'h0, sample_valid}, 0);
    at(967); chk("valid_c967", {31'h0, sample_valid}, {31'h0, STEREO});
    at(1223); chk("valid_c1223", {31'h0, sample_valid}, 1);
    at(1760);
    stop_phase();

    // Backpressure: first sample held, second dropped with one overrun pulse
    push(24'h800001, 1'b0);
    if (STEREO) begin
      push(24'h123456, 1'b0);
      push(24'hABCDEF, 1'b1);
    end
    push(24'hFFFFFF, 1'b0);
    ov0 = ov_cnt;
    start_phase(1'b0);
    at(DROP_AT);     chk("bp_overrun_hi", {31'h0, overrun}, 1);
    at(DROP_AT + 1);
    chk("bp_overrun_lo", {31'h0, overrun}, 0);
    chk("bp_valid_held", {31'h0, sample_valid}, 1);
    chk("bp_data_held", {8'h0, sample_data}, 32'h800001);
    at(REL_AT);
    sample_ready = 1'b1;
    at(1760);
    chk("bp_overrun_count", ov_cnt - ov0, 1);
    stop_phase();

    // Accept and complete in the same cycle
    push(24'h800001, 1'b0);
    push(SECOND, STEREO);
    ov0 = ov_cnt;
    start_phase(1'b0);
    at(DROP_AT - 1);
    sample_ready = 1'b1;
    at(DROP_AT);
    sample_ready = 1'b0;
    chk("sim_valid", {31'h0, sample_valid}, 1);
    chk("sim_data", {8'h0, sample_data}, {8'h0, SECOND});
    chk("sim_overrun", {31'h0, overrun}, 0);
    at(DROP_AT + 20);
    sample_ready = 1'b1;
    at(DROP_AT + 30);
    chk("sim_overrun_count", ov_cnt - ov0, 0);
    stop_phase();

    // Disable at bit 10 of the right slot
    push(24'h800001, 1'b0);
    start_phase(1'b1);
    at(852);
    chk("dis_pre_i2sclk", {31'h0, i2sclk}, 1);
    chk("dis_pre_ws", {31'h0, ws_adc}, 1);
    en = 1'b0;
    at(853);
    chk("dis_i2sclk", {31'h0, i2sclk}, 0);
    chk("dis_ws", {31'h0, ws_adc}, 0);
    vc0 = vcyc;
    at(1300);
    chk("dis_no_partial", vcyc - vc0, 0);
    stop_phase();

    // Asynchronous reset mid-slot with a sample held
    start_phase(1'b0);
    at(852);
    chk("rst_pre_valid", {31'h0, sample_valid}, 1);
    chk("rst_pre_i2sclk", {31'h0, i2sclk}, 1);
    chk("rst_pre_ws", {31'h0, ws_adc}, 1);
    #2;
    reset = 1'b1;
    en = 1'b0;
    #1;
    chk("mid_rst_i2sclk", {31'h0, i2sclk}, 0);
    chk("mid_rst_ws", {31'h0, ws_adc}, 0);
    chk("mid_rst_valid", {31'h0, sample_valid}, 0);
    chk("mid_rst_data", {8'h0, sample_data}, 0);
    chk("mid_rst_right", {31'h0, sample_right}, 0);
    chk("mid_rst_overrun", {31'h0, overrun}, 0);
    @(posedge hwclk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge hwclk);
    #1;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
